puf_disp_scan: RTL and testbench

Display scan controller for the PUF serial board: accepts a PUF response word over a valid/ready handshake and shows one response bit per 7-segment position by time-multiplexing the digit anodes. It sits directly upstream of the `hex_7seg` decoder. Each refresh slot it drives the 3-bit `hex_digit` code (0 or 1) into the decoder, and asserts the matching active-low anode. Double-buffered so a new response never tears a frame in progress.

---
 rtl/puf_disp_pkg.sv | 10 +
 rtl/puf_disp_scan_tick.sv | 33 +++
 rtl/puf_disp_scan.sv | 104 ++++++++++
 tb/tb_puf_disp_scan.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/puf_disp_pkg.sv
// puf_disp_pkg: shared states and digit codes for the PUF display scan controller.
package puf_disp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_BLANK} state_t;
  localparam int DIGIT_W = 3;
  localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 3'b000;
  localparam logic [DIGIT_W-1:0] DIGIT_ONE = 3'b001;
  function automatic logic [DIGIT_W-1:0] digit_code(input logic b);
    return b ? DIGIT_ONE : DIGIT_ZERO;
  endfunction
endpackage

// File: rtl/puf_disp_scan_tick.sv
// disp_tick_gen: loadable down-counter giving slot-end and blank-end ticks.
module disp_tick_gen #(
  parameter int SLOT_LEN = 50000,
  parameter int BLANK_LEN = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load_slot,
  input  logic i_load_blank,
  output logic o_slot_end,
  output logic o_blank_end
);
  localparam int MAXV = SLOT_LEN > BLANK_LEN ? SLOT_LEN : BLANK_LEN;
  localparam int CW = $clog2(MAXV) + 1;
  logic [CW-1:0] r_cnt;
  logic r_blank;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_blank <= 1'b0;
    end else if (i_load_slot) begin
      r_cnt <= CW'(SLOT_LEN - 1);
      r_blank <= 1'b0;
    end else if (i_load_blank) begin
      r_cnt <= CW'(BLANK_LEN - 1);
      r_blank <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_slot_end = (r_cnt == '0) && !r_blank;
  assign o_blank_end = (r_cnt == '0) && r_blank;
endmodule

// File: rtl/puf_disp_scan.sv
// puf_disp_scan: double-buffered PUF response display scanner feeding hex_7seg.
// Define PUF_DISP_BLANK_EN to insert an all-off gap between digit slots.
module puf_disp_scan
  import puf_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] resp_data,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  output logic [DIGIT_W-1:0]    hex_digit,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_idx, w_idx_nx, w_idx_inc;
  logic [NUM_DIGITS-1:0] r_pend_reg, r_disp_reg, w_disp_nx;
  logic r_pend_full, r_ready, r_frame_done;
  logic [NUM_DIGITS-1:0] r_an;
  logic [DIGIT_W-1:0] r_hex;
  logic w_cap, w_swap, w_wrap, w_last, w_load_slot, w_load_blank, w_slot_end, w_blank_end;

  disp_tick_gen #(.SLOT_LEN(REFRESH_DIV), .BLANK_LEN(BLANK_CYCLES)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .i_load_slot(w_load_slot),
    .i_load_blank(w_load_blank),
    .o_slot_end(w_slot_end),
    .o_blank_end(w_blank_end)
  );

  assign w_cap = resp_valid && r_ready;
  assign w_last = r_idx == IW'(NUM_DIGITS - 1);
  assign w_idx_inc = w_last ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx = r_idx;
    w_load_slot = 1'b0;
    w_load_blank = 1'b0;
    w_wrap = 1'b0;
    case (r_state)
      ST_IDLE: if (r_pend_full) begin
        w_state_nx = ST_SCAN;
        w_idx_nx = '0;
        w_load_slot = 1'b1;
      end
      ST_SCAN: if (w_slot_end) begin
`ifdef PUF_DISP_BLANK_EN
        w_state_nx = ST_BLANK;
        w_load_blank = 1'b1;
`else
        w_wrap = w_last;
        w_idx_nx = w_idx_inc;
        w_load_slot = 1'b1;
`endif
      end
      ST_BLANK: if (w_blank_end) begin
        w_state_nx = ST_SCAN;
        w_wrap = w_last;
        w_idx_nx = w_idx_inc;
        w_load_slot = 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_swap = r_pend_full && (r_state == ST_IDLE || w_wrap);
    w_disp_nx = w_swap ? r_pend_reg : r_disp_reg;
  end

  // Outputs are registered from next-state values so they line up with the new slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx <= '0;
      r_pend_reg <= '0;
      r_pend_full <= 1'b0;
      r_disp_reg <= '0;
      r_ready <= 1'b1;
      r_an <= '1;
      r_hex <= DIGIT_ZERO;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx <= w_idx_nx;
      r_disp_reg <= w_disp_nx;
      if (w_cap) r_pend_reg <= resp_data;
      r_pend_full <= w_cap || (r_pend_full && !w_swap);
      r_ready <= !w_cap && !r_pend_full;
      r_an <= (w_state_nx == ST_SCAN) ? ~(NUM_DIGITS'(1) << w_idx_nx) : '1;
      r_hex <= (w_state_nx == ST_SCAN) ? digit_code(w_disp_nx[w_idx_nx]) : DIGIT_ZERO;
      r_frame_done <= w_wrap;
    end
  end

  assign resp_ready = r_ready;
  assign an = r_an;
  assign hex_digit = r_hex;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_puf_disp_scan.sv
// tb_puf_disp_scan: frame-arithmetic reference model plus directed literal checks.
module tb_puf_disp_scan;
  localparam int ND = 4;
  localparam int REF = 4;
`ifdef PUF_DISP_BLANK_EN
  localparam int PER = 6;
`else
  localparam int PER = 4;
`endif
  localparam int FRAME = ND * PER;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ND-1:0] resp_data = '0;
  logic resp_valid = 1'b0;
  logic resp_ready, frame_done;
  logic [2:0] hex_digit;
  logic [ND-1:0] an;

  int vectors = 0;
  int miscompares = 0;

  puf_disp_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(REF), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .resp_data(resp_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .hex_digit(hex_digit),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  logic s_rst = 1'b0, s_valid = 1'b0;
  logic [ND-1:0] s_data = '0;
  always @(posedge clk) begin
    s_rst <= rst_n;
    s_valid <= resp_valid;
    s_data <= resp_data;
  end

  // Model: display position follows from cycles elapsed since the first lit cycle.
  initial begin
    int cyc, start, k, ph, pos;
    logic started, pend_full, ready, fd, bnd, swap, cap, lit;
    logic [ND-1:0] pend, disp, e_an;
    logic [2:0] e_hex;
    cyc = 0; start = 0; started = 0; pend_full = 0; ready = 1; fd = 0;
    pend = '0; disp = '0;
    forever begin
      @(negedge clk);
      if (!s_rst) begin
        cyc = 0; start = 0; started = 0; pend_full = 0; ready = 1; fd = 0;
        pend = '0; disp = '0;
      end else begin
        cyc++;
        k = cyc - start;
        bnd = started && k > 0 && (k % FRAME) == 0;
        swap = pend_full && (!started || bnd);
        cap = s_valid && ready;
        if (swap) disp = pend;
        if (swap && !started) begin
          started = 1;
          start = cyc;
        end
        if (cap) pend = s_data;
        ready = !cap && !pend_full;
        pend_full = cap || (pend_full && !swap);
        fd = bnd;
      end
      k = cyc - start;
      ph = k % FRAME;
      pos = ph / PER;
      lit = started && (ph % PER) < REF;
      e_an = lit ? ~(ND'(1) << pos) : '1;
      e_hex = lit ? {2'b00, disp[pos]} : 3'b000;
      chk("an", int'(an), int'(e_an));
      chk("hex_digit", int'(hex_digit), int'(e_hex));
      chk("resp_ready", int'(resp_ready), int'(ready));
      chk("frame_done", int'(frame_done), int'(fd));
      chk("an_onehot_low", int'($countones(~an) <= 1), 1);
      chk("hex_upper_zero", int'(hex_digit[2:1]), 0);
    end
  end

  logic [ND-1:0] an_tab [ND] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [2:0] hex_tab [ND] = '{3'd1, 3'd0, 3'd1, 3'd0};

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_an", int'(an), 'hF);
    chk("idle_hex", int'(hex_digit), 0);
    chk("idle_ready", int'(resp_ready), 1);

    resp_data = 4'b0101;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    chk("cap_ready_low", int'(resp_ready), 0);
    @(negedge clk);
    for (int p = 0; p < ND; p++) begin
      if (p > 0) repeat (PER) @(negedge clk);
      chk("slot_an", int'(an), int'(an_tab[p]));
      chk("slot_hex", int'(hex_digit), int'(hex_tab[p]));
    end
    repeat (FRAME - 3 * PER) @(negedge clk);
    chk("frame_done_pulse", int'(frame_done), 1);
    chk("frame_wrap_an", int'(an), 'hE);

    repeat (PER + 1) @(negedge clk);
    resp_data = 4'b1111;
    resp_valid = 1'b1;
    @(negedge clk);
    chk("mid_ready_low", int'(resp_ready), 0);
    resp_data = 4'b0000;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = resp_ready;
    end
    chk("ready_returns", int'(seen), 1);
    chk("new_frame_an", int'(an), 'hE);
    chk("new_frame_hex", int'(hex_digit), 1);
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (2 * FRAME + 2) @(negedge clk);
    chk("zero_word_hex", int'(hex_digit), 0);

    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (an == 4'b1011);
    end
    chk("reach_pos2", int'(seen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_an", int'(an), 'hF);
    chk("rst_hex", int'(hex_digit), 0);
    chk("rst_ready", int'(resp_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    resp_data = 4'b0110;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    @(negedge clk);
    chk("restart_an", int'(an), 'hE);
    chk("restart_hex", int'(hex_digit), 0);
    repeat (PER) @(negedge clk);
    chk("restart_pos1_hex", int'(hex_digit), 1);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      resp_valid = 1'($urandom_range(0, 1));
      resp_data = ND'($urandom);
    end
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
